// File: rtl/risc_controller_if.sv
// Control interface between the RISC control FSM and its datapath.
// The master side is the controller: it takes the start handshake and the
// instruction word, and drives every datapath strobe and select.
interface risc_controller_if #(
   parameter int WIDTH = 16
);
   logic             s;
   logic [WIDTH-1:0] in;
   logic             w;
   logic             illegal;
   logic [2:0]       readnum;
   logic [2:0]       writenum;
   logic             loada;
   logic             loadb;
   logic             loadc;
   logic             loads;
   logic             write;
   logic             asel;
   logic             bsel;
   logic             vsel;
   logic [1:0]       shift;
   logic [1:0]       ALUop;
   logic [WIDTH-1:0] sximm5;
   logic [WIDTH-1:0] sximm8;

   modport master (
      input  s, in,
      output w, illegal, readnum, writenum,
             loada, loadb, loadc, loads, write,
             asel, bsel, vsel, shift, ALUop, sximm5, sximm8
   );

   modport slave (
      output s, in,
      input  w, illegal, readnum, writenum,
             loada, loadb, loadc, loads, write,
             asel, bsel, vsel, shift, ALUop, sximm5, sximm8
   );
endinterface

// File: rtl/risc_controller.sv
// Multi-cycle control FSM for the RISC datapath.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_WAIT      | idle, w=1; accepts a new instruction when s=1
// ST_DECODE    | classify IR; flags illegal encodings and returns
// ST_WRITE_IMM | write sign-extended imm8 into Rn
// ST_GET_A     | read Rn into the A register
// ST_GET_B     | read Rm into the B register
// ST_ALU       | shift/ALU operation; load C (or status for CMP)
// ST_WRITE_REG | write C into Rd
module risc_controller #(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   risc_controller_if.master bus
);

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_DECODE,
      ST_WRITE_IMM,
      ST_GET_A,
      ST_GET_B,
      ST_ALU,
      ST_WRITE_REG
   } state_t;

   typedef enum logic [2:0] {
      I_MOV_IMM,
      I_MOV_REG,
      I_ADD,
      I_CMP,
      I_AND,
      I_MVN,
      I_ILLEGAL
   } instr_t;

   state_t           state;
   state_t           state_next;
   instr_t           kind;
   logic [WIDTH-1:0] ir;
   logic [2:0]       rn;
   logic [2:0]       rd;
   logic [2:0]       rm;
   logic [1:0]       sh;

   assign rn = ir[10:8];
   assign rd = ir[7:5];
   assign sh = ir[4:3];
   assign rm = ir[2:0];

   // Immediates come straight from IR so they are valid in every state.
   assign bus.sximm5 = {{(WIDTH-5){ir[4]}}, ir[4:0]};
   assign bus.sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};

   // Instruction register: loaded only on acceptance, held until the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         ir <= '0;
      end else if (state == ST_WAIT && bus.s) begin
         ir <= bus.in;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_WAIT;
      end else begin
         state <= state_next;
      end
   end

   // Instruction class from opcode/op.
   always_comb begin
      kind = I_ILLEGAL;
      case (ir[15:11])
         5'b110_10: kind = I_MOV_IMM;
         5'b110_00: kind = I_MOV_REG;
         5'b101_00: kind = I_ADD;
         5'b101_01: kind = I_CMP;
         5'b101_10: kind = I_AND;
         5'b101_11: kind = I_MVN;
         default:   kind = I_ILLEGAL;
      endcase
   end

   // Next state and Moore outputs; reset masks every output so no write
   // can leak out in the cycle an instruction is aborted.
   always_comb begin
      state_next   = state;
      bus.w        = 1'b0;
      bus.illegal  = 1'b0;
      bus.readnum  = 3'd0;
      bus.writenum = 3'd0;
      bus.loada    = 1'b0;
      bus.loadb    = 1'b0;
      bus.loadc    = 1'b0;
      bus.loads    = 1'b0;
      bus.write    = 1'b0;
      bus.asel     = 1'b0;
      bus.bsel     = 1'b0;
      bus.vsel     = 1'b0;
      bus.shift    = 2'd0;
      bus.ALUop    = 2'd0;

      if (!reset) begin
         case (state)
            ST_WAIT: begin
               bus.w = 1'b1;
               if (bus.s) state_next = ST_DECODE;
            end
            ST_DECODE: begin
               case (kind)
                  I_MOV_IMM:           state_next = ST_WRITE_IMM;
                  I_ADD, I_CMP, I_AND: state_next = ST_GET_A;
                  I_MOV_REG, I_MVN:    state_next = ST_GET_B;
                  default: begin
                     bus.illegal = 1'b1;
                     state_next  = ST_WAIT;
                  end
               endcase
            end
            ST_WRITE_IMM: begin
               bus.writenum = rn;
               bus.vsel     = 1'b1;
               bus.write    = 1'b1;
               state_next   = ST_WAIT;
            end
            ST_GET_A: begin
               bus.readnum = rn;
               bus.loada   = 1'b1;
               state_next  = ST_GET_B;
            end
            ST_GET_B: begin
               bus.readnum = rm;
               bus.loadb   = 1'b1;
               state_next  = ST_ALU;
            end
            ST_ALU: begin
               bus.shift = sh;
               case (kind)
                  I_MOV_REG: begin
                     bus.asel  = 1'b1;
                     bus.loadc = 1'b1;
                  end
                  I_ADD: begin
                     bus.loadc = 1'b1;
                  end
                  I_AND: begin
                     bus.ALUop = 2'b10;
                     bus.loadc = 1'b1;
                  end
                  I_MVN: begin
                     bus.asel  = 1'b1;
                     bus.ALUop = 2'b11;
                     bus.loadc = 1'b1;
                  end
                  I_CMP: begin
                     bus.ALUop = 2'b01;
                     bus.loads = 1'b1;
                  end
                  default: ;
               endcase
               state_next = (kind == I_CMP) ? ST_WAIT : ST_WRITE_REG;
            end
            ST_WRITE_REG: begin
               bus.writenum = rd;
               bus.write    = 1'b1;
               state_next   = ST_WAIT;
            end
            default: state_next = ST_WAIT;
         endcase
      end
   end

endmodule
